// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, reset PC and fetch-state encoding for the lab CPU
package cpu_pkg;

   localparam int ADDR_W   = 8;
   localparam int INSTR_W  = 9;
   localparam int RESET_PC = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch-to-decode valid/ready bus carrying instruction and its PC
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = cpu_pkg::ADDR_W,
   parameter int INSTR_W = cpu_pkg::INSTR_W
);

   logic               if_valid;
   logic               if_ready;
   logic [INSTR_W-1:0] if_instruction;
   logic [ADDR_W-1:0]  if_pc;

   modport master (
      output if_valid,
      output if_instruction,
      output if_pc,
      input  if_ready
   );

   modport slave (
      input  if_valid,
      input  if_instruction,
      input  if_pc,
      output if_ready
   );

endinterface

// File: rtl/fetch_pipe_reg.sv
// rtl/fetch_pipe_reg.sv - fetch/decode pipeline register with flush, load and hold
module fetch_pipe_reg #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 9
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic               flush,
   input  logic [INSTR_W-1:0] d_instruction,
   input  logic [ADDR_W-1:0]  d_pc,
   output logic               q_valid,
   output logic [INSTR_W-1:0] q_instruction,
   output logic [ADDR_W-1:0]  q_pc
);

   // Flush only drops valid; stale data is harmless once valid is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_valid       <= 1'b0;
         q_instruction <= '0;
         q_pc          <= '0;
      end else if (flush) begin
         q_valid       <= 1'b0;
      end else if (load) begin
         q_valid       <= 1'b1;
         q_instruction <= d_instruction;
         q_pc          <= d_pc;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/FSM fetch unit feeding decode; IFETCH_PERF_CNT_EN adds fetch_count
module instr_fetch_unit #(
   parameter int              ADDR_W   = cpu_pkg::ADDR_W,
   parameter int              INSTR_W  = cpu_pkg::INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_pkg::RESET_PC)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      halt,
   input  logic                      redirect_valid,
   input  logic [ADDR_W-1:0]         redirect_target,
   output logic [ADDR_W-1:0]         rom_address,
   input  logic [INSTR_W-1:0]        rom_instruction,
   instr_fetch_unit_if.master        fetch_bus,
   output logic                      running,
`ifdef IFETCH_PERF_CNT_EN
   output logic                      done,
   output logic [15:0]               fetch_count
`else
   output logic                      done
`endif
);

   import cpu_pkg::*;

   fetch_state_e      state;
   logic [ADDR_W-1:0] pc;
   logic              in_fetch;
   logic              start_ok;
   logic              load;
   logic              flush;
   logic              word_valid;

   assign in_fetch = (state == FETCH);
   assign start_ok = start && !in_fetch;
   assign flush    = in_fetch && (halt || redirect_valid);
   // A new word is taken only when the register is empty or being drained.
   assign load     = in_fetch && !halt && !redirect_valid &&
                     (!word_valid || fetch_bus.if_ready);

   assign rom_address = pc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (start) begin
                  state   <= FETCH;
                  pc      <= RESET_PC;
                  running <= 1'b1;
                  done    <= 1'b0;
               end
            end
            FETCH: begin
               if (halt) begin
                  state   <= HALTED;
                  running <= 1'b0;
                  done    <= 1'b1;
               end else if (redirect_valid) begin
                  pc <= redirect_target;
               end else if (load) begin
                  pc <= pc + ADDR_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   fetch_pipe_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_pipe (
      .clk           (clk),
      .reset_n       (reset_n),
      .load          (load),
      .flush         (flush),
      .d_instruction (rom_instruction),
      .d_pc          (pc),
      .q_valid       (word_valid),
      .q_instruction (fetch_bus.if_instruction),
      .q_pc          (fetch_bus.if_pc)
   );

   assign fetch_bus.if_valid = word_valid;

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_count <= 16'd0;
      end else if (start_ok) begin
         fetch_count <= 16'd0;
      end else if (word_valid && fetch_bus.if_ready && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end
`else
   logic unused_start_ok;
   assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic       halt;
   logic       redirect_valid;
   logic [7:0] redirect_target;
   logic [7:0] rom_address;
   logic [8:0] rom_instruction;
   logic       running;
   logic       done;
   logic [8:0] rom [256];
   logic [8:0] exp_w [5];
   int         total;
   int         bad;
   logic [15:0] exp_cnt;
`ifdef IFETCH_PERF_CNT_EN
   logic [15:0] fetch_count;
`endif

   instr_fetch_unit_if #(.ADDR_W(8), .INSTR_W(9)) fbus ();

   instr_fetch_unit dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .halt            (halt),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .rom_address     (rom_address),
      .rom_instruction (rom_instruction),
      .fetch_bus       (fbus),
      .running         (running),
`ifdef IFETCH_PERF_CNT_EN
      .done            (done),
      .fetch_count     (fetch_count)
`else
      .done            (done)
`endif
   );

   assign rom_instruction = rom[rom_address];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock, with the expected handshake count tracked from pre-edge inputs.
   task automatic step();
      logic hs;
      logic st;
      hs = fbus.if_valid && fbus.if_ready;
      st = start && !running;
      @(posedge clk);
      #1;
      if (st) exp_cnt = 16'd0;
      else if (hs && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic chk_cnt(input string tag);
`ifdef IFETCH_PERF_CNT_EN
      chk(tag, 32'(fetch_count), 32'(exp_cnt));
`else
      if (tag.len() == 0) total++;
`endif
   endtask

   initial begin
      clk = 1'b0;
      reset_n = 1'b0;
      start = 1'b0;
      halt = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 8'h00;
      fbus.if_ready = 1'b0;
      total = 0;
      bad = 0;
      exp_cnt = 16'd0;
      for (int i = 0; i < 256; i++) rom[i] = 9'h1A5 ^ 9'(i);
      rom[0] = 9'h140; rom[1] = 9'h140; rom[2] = 9'h161; rom[3] = 9'h0AA; rom[4] = 9'h00A;
      rom[8'h40] = 9'h1C3; rom[8'h41] = 9'h055; rom[8'hFF] = 9'h1FF;
      exp_w[0] = 9'h140; exp_w[1] = 9'h140; exp_w[2] = 9'h161; exp_w[3] = 9'h0AA; exp_w[4] = 9'h00A;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(fbus.if_valid), 32'd0);
      chk("rst_instr", 32'(fbus.if_instruction), 32'd0);
      chk("rst_pc", 32'(fbus.if_pc), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(rom_address), 32'd0);
      chk_cnt("rst_count");
      reset_n = 1'b1;
      step();

      halt = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h33;
      step();
      halt = 1'b0; redirect_valid = 1'b0;
      chk("idle_addr", 32'(rom_address), 32'd0);
      chk("idle_running", 32'(running), 32'd0);
      chk("idle_done", 32'(done), 32'd0);

      start = 1'b1;
      step();
      start = 1'b0; fbus.if_ready = 1'b1;
      chk("start_running", 32'(running), 32'd1);
      chk("start_valid", 32'(fbus.if_valid), 32'd0);
      chk("start_addr", 32'(rom_address), 32'd0);

      for (int i = 0; i < 5; i++) begin
         step();
         chk("stream_valid", 32'(fbus.if_valid), 32'd1);
         chk("stream_instr", 32'(fbus.if_instruction), 32'(exp_w[i]));
         chk("stream_pc", 32'(fbus.if_pc), 32'(i));
         chk_cnt("stream_count");
      end

      start = 1'b1;
      step();
      start = 1'b0;
      chk("fetch_start_pc", 32'(fbus.if_pc), 32'd5);
      chk("fetch_start_addr", 32'(rom_address), 32'd6);

      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("halt_done", 32'(done), 32'd1);
      chk("halt_running", 32'(running), 32'd0);
      chk("halt_valid", 32'(fbus.if_valid), 32'd0);
      chk("halt_addr", 32'(rom_address), 32'd6);

      redirect_valid = 1'b1; redirect_target = 8'h20;
      step();
      redirect_valid = 1'b0;
      chk("halted_redir_addr", 32'(rom_address), 32'd6);
      chk("halted_done", 32'(done), 32'd1);

      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_running", 32'(running), 32'd1);
      chk("restart_done", 32'(done), 32'd0);
      chk("restart_valid", 32'(fbus.if_valid), 32'd0);
      chk("restart_addr", 32'(rom_address), 32'd0);
      chk_cnt("restart_count");

      repeat (3) step();
      chk("pre_stall_instr", 32'(fbus.if_instruction), 32'h161);
      chk("pre_stall_pc", 32'(fbus.if_pc), 32'd2);
      fbus.if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", 32'(fbus.if_valid), 32'd1);
         chk("stall_instr", 32'(fbus.if_instruction), 32'h161);
         chk("stall_pc", 32'(fbus.if_pc), 32'd2);
         chk("stall_addr", 32'(rom_address), 32'd3);
      end
      fbus.if_ready = 1'b1;
      step();
      chk("release_pc", 32'(fbus.if_pc), 32'd3);
      chk("release_instr", 32'(fbus.if_instruction), 32'h0AA);
      chk_cnt("release_count");

      redirect_valid = 1'b1; redirect_target = 8'h40;
      step();
      redirect_valid = 1'b0;
      chk("redir_valid", 32'(fbus.if_valid), 32'd0);
      chk("redir_addr", 32'(rom_address), 32'h40);
      step();
      chk("redir_tgt_valid", 32'(fbus.if_valid), 32'd1);
      chk("redir_tgt_pc", 32'(fbus.if_pc), 32'h40);
      chk("redir_tgt_instr", 32'(fbus.if_instruction), 32'h1C3);

      halt = 1'b1; redirect_valid = 1'b1; redirect_target = 8'h40;
      step();
      halt = 1'b0; redirect_valid = 1'b0;
      chk("hr_done", 32'(done), 32'd1);
      chk("hr_running", 32'(running), 32'd0);
      chk("hr_valid", 32'(fbus.if_valid), 32'd0);
      chk("hr_addr", 32'(rom_address), 32'h41);

      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk("refetch_pc", 32'(fbus.if_pc), 32'd0);
      chk("refetch_instr", 32'(fbus.if_instruction), 32'h140);
      chk_cnt("refetch_count");

      redirect_valid = 1'b1; redirect_target = 8'hFF;
      step();
      redirect_valid = 1'b0;
      chk("wrap_flush_valid", 32'(fbus.if_valid), 32'd0);
      chk_cnt("wrap_count0");
      step();
      chk("wrap_pc_ff", 32'(fbus.if_pc), 32'hFF);
      chk("wrap_instr_ff", 32'(fbus.if_instruction), 32'h1FF);
      chk_cnt("wrap_count1");
      step();
      chk("wrap_pc_00", 32'(fbus.if_pc), 32'h00);
      chk("wrap_instr_00", 32'(fbus.if_instruction), 32'h140);
      chk_cnt("wrap_count2");
      step();
      chk("wrap_pc_01", 32'(fbus.if_pc), 32'h01);
      chk_cnt("wrap_count3");

      #2;
      reset_n = 1'b0;
      #1;
      exp_cnt = 16'd0;
      chk("async_valid", 32'(fbus.if_valid), 32'd0);
      chk("async_instr", 32'(fbus.if_instruction), 32'd0);
      chk("async_pc", 32'(fbus.if_pc), 32'd0);
      chk("async_running", 32'(running), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      chk("async_addr", 32'(rom_address), 32'd0);
      chk_cnt("async_count");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      chk("post_rst_addr", 32'(rom_address), 32'd0);
      chk("post_rst_running", 32'(running), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
